// File: rtl/delay_assert_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : delay_assert_sched_pkg
//  Purpose : Shared types and helpers for the multi-attempt delay-assertion
//            scheduler (a |-> ##[MIN_DELAY:MAX_DELAY] b).
//  Contents: slot_state_e (FREE/WAIT/WINDOW), width localparams for the
//            default configuration, saturating-add helper.
//  Optional: DELAY_ASSERT_SCHED_FIRST_FAIL_EN (used by the top module).
//  Revision: 1.0 - initial release
// ============================================================================
package delay_assert_sched_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    WINDOW = 2'd2
  } slot_state_e;

  // Widths for the default configuration (NUM_SLOTS=4, MAX_DELAY=3).
  // Parameterised modules recompute these from their own parameters.
  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_MAX_DELAY = 3;
  localparam int AGE_W         = $clog2(DEF_MAX_DELAY + 1);
  localparam int SLOT_IDX_W    = (DEF_NUM_SLOTS > 1) ? $clog2(DEF_NUM_SLOTS) : 1;

  // acc + inc, clamped to max_val. Evaluated in 33 bits so the carry out of
  // a 32-bit counter is still seen.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay_assert_slot.sv
`default_nettype none
// ============================================================================
//  Module  : delay_assert_slot
//  Purpose : One attempt tracker. Allocated on a trigger, ages once per
//            cycle and resolves to pass (b seen inside the window) or fail
//            (window closed at MAX_DELAY without b).
//  Ports   : clk, rst      - clock, synchronous active-high reset
//            alloc         - claim this slot (only honoured while FREE)
//            b             - consequent
//            busy          - slot is not FREE
//            pass_ev       - resolving pass this cycle (combinational)
//            fail_ev       - resolving fail this cycle (combinational)
//  Revision: 1.0 - initial release
// ============================================================================
module delay_assert_slot
  import delay_assert_sched_pkg::*;
#(
  parameter int MIN_DELAY = 1,
  parameter int MAX_DELAY = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  logic b,
  output logic busy,
  output logic pass_ev,
  output logic fail_ev
);

  localparam int AW = $clog2(MAX_DELAY + 1);

  slot_state_e   state, state_n;
  logic [AW-1:0] age, age_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FREE;
      age   <= '0;
    end else begin
      state <= state_n;
      age   <= age_n;
    end
  end

  always_comb begin
    state_n = state;
    age_n   = age;
    pass_ev = 1'b0;
    fail_ev = 1'b0;
    case (state)
      FREE: begin
        if (alloc) begin
          // Age counts cycles since the trigger, so it is 1 in the first
          // cycle after allocation; with MIN_DELAY==1 that cycle is checked.
          age_n   = AW'(1);
          state_n = (MIN_DELAY <= 1) ? WINDOW : WAIT;
        end
      end
      WAIT: begin
        age_n = age + AW'(1);
        if (age_n >= AW'(MIN_DELAY)) begin
          state_n = WINDOW;
        end
      end
      WINDOW: begin
        if (b) begin
          pass_ev = 1'b1;
          state_n = FREE;
          age_n   = '0;
        end else if (age == AW'(MAX_DELAY)) begin
          fail_ev = 1'b1;
          state_n = FREE;
          age_n   = '0;
        end else begin
          age_n = age + AW'(1);
        end
      end
      default: begin
        state_n = FREE;
        age_n   = '0;
      end
    endcase
  end

  assign busy = (state != FREE);

endmodule
`default_nettype wire

// File: rtl/delay_assert_thread_sched.sv
`default_nettype none
// ============================================================================
//  Module  : delay_assert_thread_sched
//  Purpose : Shares NUM_SLOTS attempt trackers between overlapping triggers
//            of a |-> ##[MIN_DELAY:MAX_DELAY] b and aggregates the results.
//  Ports   : clk, rst           - clock, synchronous active-high reset
//            enable, a, b       - gate, antecedent, consequent
//            clear_stats        - zero counters and overflow
//            assertion_pass/fail- registered result pulses
//            assertion_active   - at least one slot busy (registered)
//            active_slots       - busy slot count (registered)
//            overflow           - sticky dropped-trigger flag
//            pass_count/fail_count - saturating statistics
//            first_fail_valid/first_fail_cycle - only with
//                                 DELAY_ASSERT_SCHED_FIRST_FAIL_EN defined
//  Optional: DELAY_ASSERT_SCHED_FIRST_FAIL_EN
//  Revision: 1.0 - initial release
// ============================================================================
module delay_assert_thread_sched
  import delay_assert_sched_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int MIN_DELAY = 1,
  parameter int MAX_DELAY = 3,
  parameter int STAT_W    = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic                             a,
  input  logic                             b,
  input  logic                             clear_stats,
  output logic                             assertion_pass,
  output logic                             assertion_fail,
  output logic                             assertion_active,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   active_slots,
  output logic                             overflow,
  output logic [STAT_W-1:0]                pass_count,
`ifdef DELAY_ASSERT_SCHED_FIRST_FAIL_EN
  output logic                             first_fail_valid,
  output logic [STAT_W-1:0]                first_fail_cycle,
`endif
  output logic [STAT_W-1:0]                fail_count
);

  localparam int          CNT_W    = $clog2(NUM_SLOTS + 1);
  localparam logic [31:0] STAT_MAX = 32'((64'd1 << STAT_W) - 64'd1);

  logic                 trig;
  logic [NUM_SLOTS-1:0] busy, free_v, alloc, pass_ev, fail_ev, occ_next;
  logic [CNT_W-1:0]     n_pass, n_fail, n_occ;

  assign trig   = a & enable;
  assign free_v = ~busy;
  // x & -x isolates the lowest set bit: lowest-index slot free at cycle start.
  assign alloc  = trig ? (free_v & (~free_v + NUM_SLOTS'(1))) : '0;

  // Occupancy after the edge: survivors plus the newly allocated slot.
  assign occ_next = (busy & ~(pass_ev | fail_ev)) | alloc;

  generate
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      delay_assert_slot #(
        .MIN_DELAY(MIN_DELAY),
        .MAX_DELAY(MAX_DELAY)
      ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .alloc  (alloc[i]),
        .b      (b),
        .busy   (busy[i]),
        .pass_ev(pass_ev[i]),
        .fail_ev(fail_ev[i])
      );
    end
  endgenerate

  always_comb begin
    n_pass = '0;
    n_fail = '0;
    n_occ  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      n_pass = n_pass + CNT_W'(pass_ev[i]);
      n_fail = n_fail + CNT_W'(fail_ev[i]);
      n_occ  = n_occ  + CNT_W'(occ_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assertion_pass   <= 1'b0;
      assertion_fail   <= 1'b0;
      assertion_active <= 1'b0;
      active_slots     <= '0;
      overflow         <= 1'b0;
      pass_count       <= '0;
      fail_count       <= '0;
    end else begin
      assertion_pass   <= |pass_ev;
      assertion_fail   <= |fail_ev;
      assertion_active <= |occ_next;
      active_slots     <= n_occ;
      if (clear_stats) begin
        overflow   <= 1'b0;
        pass_count <= '0;
        fail_count <= '0;
      end else begin
        if (trig && (&busy)) begin
          overflow <= 1'b1;
        end
        pass_count <= STAT_W'(sat_add(32'(pass_count), 32'(n_pass), STAT_MAX));
        fail_count <= STAT_W'(sat_add(32'(fail_count), 32'(n_fail), STAT_MAX));
      end
    end
  end

`ifdef DELAY_ASSERT_SCHED_FIRST_FAIL_EN
  logic [STAT_W-1:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_cycle <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + STAT_W'(1);
      if (clear_stats) begin
        first_fail_valid <= 1'b0;
        first_fail_cycle <= '0;
      end else if ((|fail_ev) && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_cycle <= cycle_cnt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/delay_assert_thread_sched.md
Name: delay_assert_thread_sched

Overview:
Multi-attempt controller for the delay-assertion checker property `a |-> ##[MIN_DELAY:MAX_DELAY] b`.
- A single checker FSM can track only one attempt at a time. This block shares a pool of NUM_SLOTS attempt trackers between overlapping triggers of `a`.
- It allocates a slot per trigger, ages each slot, and resolves each attempt to pass or fail.
- It aggregates results into the standard pass/fail/active outputs plus statistics counters.
- It sits beside the generated checkers in the assertion-to-RTL flow and is instantiated once per delay property.

Parameters:
- NUM_SLOTS, 4, number of concurrent attempts tracked.
- MIN_DELAY, 1, first cycle after trigger at which `b` is checked; must be >= 1.
- MAX_DELAY, 3, last cycle after trigger at which `b` is checked; must be >= MIN_DELAY.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  when high, a trigger on `a` may allocate a slot.
- a  in  1  antecedent.
- b  in  1  consequent.
- clear_stats  in  1  synchronously clears counters and overflow.
- assertion_pass  out  1  registered pulse: at least one attempt passed.
- assertion_fail  out  1  registered pulse: at least one attempt failed.
- assertion_active  out  1  at least one slot busy.
- active_slots  out  $clog2(NUM_SLOTS+1)  count of busy slots.
- overflow  out  1  sticky: a trigger was dropped because no slot was free.
- pass_count  out  STAT_W  saturating total of passes.
- fail_count  out  STAT_W  saturating total of fails.

Behaviour:
- Reset: all slots FREE with age 0. Every output is 0.
- Per-slot FSM:
  - FREE -> WAIT on allocation, with age=1 in the following cycle.
  - WAIT (age<MIN_DELAY) -> age++; moves to WINDOW when age reaches MIN_DELAY.
  - WINDOW: if `b`=1, record a pass and go to FREE. Otherwise, if age==MAX_DELAY, record a fail and go to FREE. Otherwise age++.
  - When MIN_DELAY==1 the allocated slot enters WINDOW directly.
- Allocation:
  - Occurs when `a && enable`.
  - Takes the lowest-index slot that is FREE at the start of the cycle.
  - A slot resolving this cycle becomes allocatable next cycle.
- Overflow: `a && enable` with no FREE slot drops the trigger and sets `overflow` (registered, sticky).
- Latency:
  - A trigger sampled in cycle t checks `b` in cycles t+MIN_DELAY .. t+MAX_DELAY.
  - assertion_pass/assertion_fail assert one cycle after the resolving cycle.
- Simultaneous resolution:
  - Multiple slots may resolve in the same cycle.
  - pass_count/fail_count add the popcount of the resolving slots, saturating at all-ones.
  - Pass and fail may both pulse in the same cycle.
- enable low: no new allocation; busy slots continue to age and resolve.
- active_slots/assertion_active are registered and reflect slot occupancy after the clock edge.
- clear_stats:
  - Zeroes pass_count, fail_count and overflow; clear wins over same-cycle increments.
  - Does not affect slots or the pass/fail pulses.
- rst mid-operation: all in-flight attempts are discarded with no pass/fail pulse; counters return to 0.

Optional Feature:
Macro: DELAY_ASSERT_SCHED_FIRST_FAIL_EN
- Defined:
  - Adds a free-running STAT_W-bit cycle counter, reset to 0.
  - Adds outputs first_fail_valid (1b) and first_fail_cycle (STAT_W), latching the counter value of the first resolving-fail cycle after reset or clear_stats.
  - Later fails are ignored until clear_stats.
- Undefined: these outputs and the counter do not exist.

Decomposition:
- Package delay_assert_sched_pkg holds:
  - the slot_state_e enum (FREE, WAIT, WINDOW);
  - localparams AGE_W=$clog2(MAX_DELAY+1) and SLOT_IDX_W;
  - the saturating-add function.
- Sub-module delay_assert_slot:
  - One attempt tracker with inputs alloc and b.
  - Outputs busy, pass_ev and fail_ev.
  - Top instantiates NUM_SLOTS copies, plus the priority allocator and aggregation logic.

Test Plan:
All scenarios use defaults unless noted: NUM_SLOTS=4, MIN_DELAY=1, MAX_DELAY=3.
1. `a`=1 in cycle 0 only, `b`=1 in cycle 2 -> assertion_pass=1 in cycle 3; pass_count=1; active_slots back to 0 in cycle 3.
2. `a`=1 in cycle 0, `b` held 0 -> assertion_fail=1 in cycle 4; fail_count=1; no pass pulse.
3. `a`=1 cycles 0-3, `b`=1 only in cycle 4 -> fail pulse cycle 4 (attempt 0); pass pulse cycle 5; pass_count=3, fail_count=1.
4. NUM_SLOTS=2, `a`=1 cycles 0-3, `b`=0 -> cycle 2 trigger dropped, overflow=1 from cycle 3 and stays 1; active_slots=2 in cycles 2-3.
5. clear_stats=1 in the same cycle an attempt resolves pass -> pass_count=0 next cycle; assertion_pass still pulses.
6. Three slots busy, rst=1 for one cycle -> next cycle active_slots=0, all outputs 0, no pass/fail pulses from the discarded attempts.
